mux4_rr_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one WIDTH-bit output channel (a mux4to1 instance) among

---
 rtl/mux4_rr_arbiter_if.sv | 16 +
 rtl/mux4_rr_arbiter.sv | 120 ++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 114 +++++++++++
 3 files changed

// File: rtl/mux4_rr_arbiter_if.sv
// Shared output channel bundle: four requesters in, one granted valid/ready stream out.
// The arbiter connects through the master modport; producers and the consumer use slave.
interface mux4_rr_arbiter_if #(parameter int WIDTH = 4);
  logic [3:0]       req;
  logic [WIDTH-1:0] I0, I1, I2, I3;
  logic             out_ready;
  logic [3:0]       grant;
  logic [1:0]       Sel;
  logic [WIDTH-1:0] Data_out;
  logic             out_valid;

  modport master (input req, I0, I1, I2, I3, out_ready,
                  output grant, Sel, Data_out, out_valid);
  modport slave  (output req, I0, I1, I2, I3, out_ready,
                  input grant, Sel, Data_out, out_valid);
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one mux4to1 output channel among four requesters,
// rotating ownership after HOLD_MAX accepted beats or when the owner drops req.
module mux4to1 #(
  parameter int WIDTH = 4
) (
  input  logic [1:0]       sel,
  input  logic [WIDTH-1:0] i0, i1, i2, i3,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    case (sel)
      2'd0:    y = i0;
      2'd1:    y = i1;
      2'd2:    y = i2;
      default: y = i3;
    endcase
  end
endmodule

module mux4_rr_arbiter #(
  parameter int WIDTH    = 4,
  parameter int HOLD_MAX = 2
) (
  input logic               clk,
  input logic               rst_n,
  mux4_rr_arbiter_if.master bus
);
  localparam int CW = $clog2(HOLD_MAX + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_q, state_n;
  logic [3:0]      grant_q, grant_n;
  logic [1:0]      sel_q, sel_n;
  logic [1:0]      ptr_q, ptr_n;
  logic [CW-1:0]   cnt_q, cnt_n;
  logic [CW-1:0]   cnt_inc;
  logic [2:0]      win_idle, win_rot;

  // {found, index} of the first set request scanning start, start+1, ... mod 4
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 3; k >= 0; k--) begin
      idx = start + 2'(k);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      grant_q <= grant_n;
      sel_q   <= sel_n;
      ptr_q   <= ptr_n;
      cnt_q   <= cnt_n;
    end
  end

  assign cnt_inc  = cnt_q + CW'(1);
  assign win_idle = pick(bus.req, ptr_q);
  // On rotation the current owner is scanned last
  assign win_rot  = pick(bus.req, sel_q + 2'd1);

  always_comb begin
    state_n = state_q;
    grant_n = grant_q;
    sel_n   = sel_q;
    ptr_n   = ptr_q;
    cnt_n   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_idle[2]) begin
          state_n = BUSY;
          grant_n = 4'b0001 << win_idle[1:0];
          sel_n   = win_idle[1:0];
          cnt_n   = '0;
        end
      end
      default: begin
        if (bus.out_ready) begin
          if (bus.req[sel_q] && (cnt_inc < CW'(HOLD_MAX))) begin
            cnt_n = cnt_inc;
          end else begin
            ptr_n = sel_q + 2'd1;
            cnt_n = '0;
            if (win_rot[2]) begin
              grant_n = 4'b0001 << win_rot[1:0];
              sel_n   = win_rot[1:0];
            end else begin
              state_n = IDLE;
              grant_n = '0;
            end
          end
        end
      end
    endcase
  end

  always_comb begin
    bus.out_valid = (state_q == BUSY);
    bus.grant     = grant_q;
    bus.Sel       = sel_q;
  end

  mux4to1 #(.WIDTH(WIDTH)) u_mux (
    .sel (sel_q),
    .i0  (bus.I0),
    .i1  (bus.I1),
    .i2  (bus.I2),
    .i3  (bus.I3),
    .y   (bus.Data_out)
  );
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench: HOLD_MAX=2 instance for reset/hold/stall/release cases,
// HOLD_MAX=1 instance for strict per-beat rotation.
module tb_mux4_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mux4_rr_arbiter_if #(.WIDTH(4)) ba ();
  mux4_rr_arbiter_if #(.WIDTH(4)) bb ();

  mux4_rr_arbiter #(.WIDTH(4), .HOLD_MAX(2)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ba.master));
  mux4_rr_arbiter #(.WIDTH(4), .HOLD_MAX(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bb.master));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input logic [3:0] g, input logic [1:0] s,
                       input logic v, input logic [3:0] d);
    chk({tag, ".grant"}, 32'(ba.grant), 32'(g));
    chk({tag, ".sel"},   32'(ba.Sel),   32'(s));
    chk({tag, ".valid"}, 32'(ba.out_valid), 32'(v));
    if (v) chk({tag, ".data"}, 32'(ba.Data_out), 32'(d));
  endtask

  logic [3:0] seq3 [10] = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100,
                            4'b0100, 4'b1000, 4'b1000, 4'b0001, 4'b0001};
  logic [3:0] seq6 [4]  = '{4'b1000, 4'b0001, 4'b1000, 4'b0001};

  initial begin
    ba.req = '0; ba.out_ready = 1'b0;
    ba.I0 = 4'h5; ba.I1 = 4'h6; ba.I2 = 4'hA; ba.I3 = 4'hC;
    bb.req = '0; bb.out_ready = 1'b0;
    bb.I0 = 4'h1; bb.I1 = 4'h2; bb.I2 = 4'h3; bb.I3 = 4'h4;

    #12;
    chk("rst.grant", 32'(ba.grant), 32'h0);
    chk("rst.sel",   32'(ba.Sel), 32'h0);
    chk("rst.valid", 32'(ba.out_valid), 32'h0);
    chk("rst.data_i0", 32'(ba.Data_out), 32'h5);
    rst_n = 1'b1;
    step();

    // Sole requester 2: two beats, then re-granted with no bubble
    ba.req = 4'b0100; ba.out_ready = 1'b1;
    step(); chk_a("t2.first", 4'b0100, 2'd2, 1'b1, 4'hA);
    step(); chk_a("t2.beat1", 4'b0100, 2'd2, 1'b1, 4'hA);
    step(); chk_a("t2.regrant", 4'b0100, 2'd2, 1'b1, 4'hA);

    // Async reset mid-BUSY
    #2 rst_n = 1'b0;
    #1 chk_a("t1.async", 4'b0000, 2'd0, 1'b0, 4'h0);
    ba.req = '0;
    #1 rst_n = 1'b1;
    step(); chk_a("t1.idle0", 4'b0000, 2'd0, 1'b0, 4'h0);
    step(); chk_a("t1.idle1", 4'b0000, 2'd0, 1'b0, 4'h0);

    // All requesting from ptr=0: two beats each in order
    ba.req = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("t3.g%0d", i), 32'(ba.grant), 32'(seq3[i]));
      chk($sformatf("t3.v%0d", i), 32'(ba.out_valid), 32'h1);
    end

    // Stall with owner 1: everything held while out_ready=0
    step(); chk_a("t4.own1", 4'b0010, 2'd1, 1'b1, 4'h6);
    ba.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(); chk_a($sformatf("t4.stall%0d", i), 4'b0010, 2'd1, 1'b1, 4'h6);
    end
    ba.out_ready = 1'b1;
    step(); chk_a("t4.beat1", 4'b0010, 2'd1, 1'b1, 4'h6);
    step(); chk_a("t4.rot", 4'b0100, 2'd2, 1'b1, 4'hA);

    // Drain to IDLE (ptr becomes 3), then owner 0 releases after one beat
    ba.req = 4'b0000;
    step(); chk_a("t5.idle", 4'b0000, 2'd2, 1'b0, 4'h0);
    ba.req = 4'b0001;
    step(); chk_a("t5.own0", 4'b0001, 2'd0, 1'b1, 4'h5);
    ba.req = 4'b1000;
    step(); chk_a("t5.own3", 4'b1000, 2'd3, 1'b1, 4'hC);
    ba.req = 4'b0000;
    step(); chk_a("t5.end", 4'b0000, 2'd3, 1'b0, 4'h0);
    ba.out_ready = 1'b0;

    // HOLD_MAX=1: one beat to 2 then idle leaves ptr=3; req=1001 alternates 3,0
    bb.req = 4'b0100; bb.out_ready = 1'b1;
    step(); chk("t6.own2", 32'(bb.grant), 32'b0100);
    bb.req = 4'b0000;
    step(); chk("t6.idle", 32'(bb.out_valid), 32'h0);
    bb.req = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("t6.g%0d", i), 32'(bb.grant), 32'(seq6[i]));
      chk($sformatf("t6.d%0d", i), 32'(bb.Data_out), (seq6[i] == 4'b1000) ? 32'h4 : 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
